// File: rtl/sdpram_stream_reader_pkg.sv
// Shared constants and types for the port-B stream reader.
package sdpram_pkg;

   localparam int SDP_ADDR_W = 6;
   localparam int SDP_DATA_W = 32;
   localparam int SDP_RD_LAT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/sdpram_stream_reader_if.sv
// Command and output-stream handshake bundle of the stream reader.
// The master modport is the reader's view; slave is the user's view.
interface sdpram_stream_reader_if
   import sdpram_pkg::*;
#(
   parameter int ADDR_W = SDP_ADDR_W,
   parameter int DATA_W = SDP_DATA_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W:0]   cmd_len;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, m_ready,
      output cmd_ready, m_valid, m_data, m_last
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, m_ready,
      input  cmd_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/sdpram_rd_fifo.sv
// Return buffer for read data. The front entry lives in a dedicated head
// register so the stream outputs come straight from flops; the remaining
// entries sit in an array with a registered read into that head.
module sdpram_rd_fifo
   import sdpram_pkg::*;
#(
   parameter  int WIDTH = SDP_DATA_W + 1,
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] store [DEPTH];
   logic [WIDTH-1:0] head_reg;
   logic             head_valid_reg;
   logic [CNT_W-1:0] count_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;

   logic             pop_ok;
   logic             load_head;
   logic             body_has;
   logic             body_rd;
   logic             bypass;
   logic             body_wr;
   logic [CNT_W-1:0] body_cnt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Decide where a push lands and whether the head must be refilled
   always_comb begin
      pop_ok    = pop && head_valid_reg;
      body_cnt  = count_reg - CNT_W'(head_valid_reg);
      load_head = !head_valid_reg || pop_ok;
      body_has  = (body_cnt != '0);
      body_rd   = load_head && body_has;
      bypass    = load_head && !body_has && push;
      body_wr   = push && !bypass;
   end

   // Body storage: plain array write, no reset so it maps to RAM
   always_ff @(posedge clk) begin
      if (body_wr) begin
         store[wr_ptr_reg] <= din;
      end
   end

   // Head register, pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg       <= '0;
         head_valid_reg <= 1'b0;
         count_reg      <= '0;
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
      end else begin
         if (body_rd) begin
            head_reg   <= store[rd_ptr_reg];
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end else if (bypass) begin
            head_reg <= din;
         end
         if (load_head) begin
            head_valid_reg <= body_rd || bypass;
         end
         if (body_wr) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop_ok);
      end
   end

   assign head  = head_reg;
   assign empty = !head_valid_reg;
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign count = count_reg;

endmodule

// File: rtl/sdpram_stream_reader.sv
// Read-side engine for the simple dual-port RAM: takes (addr, len) commands,
// issues one port-B read per cycle while return-buffer credit exists, tracks
// the fixed read latency and streams the data out with a last flag.
module sdpram_stream_reader
   import sdpram_pkg::*;
#(
   parameter int ADDR_W     = SDP_ADDR_W,
   parameter int DATA_W     = SDP_DATA_W,
   parameter int RD_LAT     = SDP_RD_LAT,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   sdpram_stream_reader_if.master bus,
   output logic                  mem_enb,
   output logic [ADDR_W-1:0]     mem_addrb,
   input  logic [DATA_W-1:0]     mem_doutb,
   output logic                  busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   if (FIFO_DEPTH < RD_LAT + 2) begin : g_bad_depth
      $error("sdpram_stream_reader: FIFO_DEPTH must be at least RD_LAT+2");
   end

   rd_state_t         state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W:0]   rem_reg, rem_next;
   logic              mem_enb_reg;
   logic              mem_last_reg;
   logic [ADDR_W-1:0] mem_addrb_reg;
   logic [RD_LAT-1:0] vsr_reg;
   logic [RD_LAT-1:0] lsr_reg;
   logic [CNT_W-1:0]  inflight_reg;

   logic              issue;
   logic              capture;
   logic              pop;
   logic [OCC_W-1:0]  occupancy;
   logic              drain_done;

   logic [DATA_W:0]   fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   assign capture = vsr_reg[RD_LAT-1];
   assign pop     = !fifo_empty && bus.m_ready;

   // Reads in flight plus buffered beats, net of a beat leaving this cycle;
   // a capture this cycle only moves a beat between the two terms.
   assign occupancy  = OCC_W'(inflight_reg) + OCC_W'(fifo_count) - OCC_W'(pop);
   assign drain_done = (inflight_reg == '0) &&
                       (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

   // Next-state, issue decision and address/remaining bookkeeping
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      rem_next   = rem_reg;
      issue      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.cmd_valid && (bus.cmd_len != '0)) begin
               addr_next  = bus.cmd_addr;
               rem_next   = bus.cmd_len;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (occupancy < OCC_W'(FIFO_DEPTH)) begin
               issue     = 1'b1;
               addr_next = addr_reg + ADDR_W'(1);
               rem_next  = rem_reg - (ADDR_W + 1)'(1);
               if (rem_reg == (ADDR_W + 1)'(1)) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM, command registers, registered port-B drive and in-flight count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         rem_reg       <= '0;
         mem_enb_reg   <= 1'b0;
         mem_last_reg  <= 1'b0;
         mem_addrb_reg <= '0;
         inflight_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         rem_reg      <= rem_next;
         mem_enb_reg  <= issue;
         mem_last_reg <= issue && (rem_reg == (ADDR_W + 1)'(1));
         if (issue) begin
            mem_addrb_reg <= addr_reg;
         end
         inflight_reg <= inflight_reg + CNT_W'(issue) - CNT_W'(capture);
      end
   end

   // Valid/last pipelines matching the RAM latency after mem_enb
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsr_reg <= '0;
         lsr_reg <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            vsr_reg[i] <= vsr_reg[i-1];
            lsr_reg[i] <= lsr_reg[i-1];
         end
         vsr_reg[0] <= mem_enb_reg;
         lsr_reg[0] <= mem_last_reg;
      end
   end

   sdpram_rd_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (capture),
      .din   ({mem_doutb, lsr_reg[RD_LAT-1]}),
      .pop   (pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A capture into a full buffer would mean the credit check is broken
   assert property (@(posedge clk) disable iff (rst) !(capture && fifo_full));

   assign mem_enb       = mem_enb_reg;
   assign mem_addrb     = mem_addrb_reg;
   assign busy          = (state_reg != IDLE);
   assign bus.cmd_ready = (state_reg == IDLE);
   assign bus.m_valid   = !fifo_empty;
   assign bus.m_data    = fifo_head[DATA_W:1];
   assign bus.m_last    = fifo_head[0];

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Bench for sdpram_stream_reader: a latency-accurate RAM model feeds port B,
// and every beat is compared with mem[(addr+i) mod depth] from the command.
module tb_sdpram_stream_reader;
   import sdpram_pkg::*;

   localparam int AW     = SDP_ADDR_W;
   localparam int DW     = SDP_DATA_W;
   localparam int LAT    = SDP_RD_LAT;
   localparam int DEPTH  = 8;
   localparam int NWORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_enb;
   logic [AW-1:0] mem_addrb;
   logic [DW-1:0] mem_doutb;
   logic          busy;

   logic [DW-1:0] ram   [NWORDS];
   logic [DW-1:0] rpipe [LAT];

   int vectors     = 0;
   int miscompares = 0;

   sdpram_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   sdpram_stream_reader #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RD_LAT     (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .mem_enb   (mem_enb),
      .mem_addrb (mem_addrb),
      .mem_doutb (mem_doutb),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // RAM port B: data appears LAT cycles after the address is presented
   always @(posedge clk) begin
      rpipe[0] <= ram[mem_addrb];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign mem_doutb = rpipe[LAT-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one command from offer to completion. Entered and left at #1 after an edge.
   task automatic run_cmd(input int a, input int len, input int ready_pct, input int hold,
                          input int abort_after, input bit chk_lat, input bit poke);
      int issued = 0, beats = 0, n = 0, first_e = -1, first_v = -1, worst_out = 0;
      bit prev_stall = 0, done = 0, aborted = 0, timed_out = 0;
      logic [DW-1:0] prev_data = '0;
      logic prev_last = 1'b0;
      check("cmd_ready_idle", bus_if.cmd_ready, 1);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_addr  = AW'(a);
      bus_if.cmd_len   = (AW + 1)'(len);
      bus_if.m_ready   = 1'b0;
      @(posedge clk); #1;
      bus_if.cmd_valid = 1'b0;
      while (!done) begin
         if (mem_enb) begin
            check("rd_addr", mem_addrb, (a + issued) % NWORDS);
            if (first_e < 0) first_e = n;
            issued++;
         end
         if (issued - beats > worst_out) worst_out = issued - beats;
         if (prev_stall) begin
            check("hold_valid", bus_if.m_valid, 1);
            check("hold_data", bus_if.m_data, prev_data);
            check("hold_last", bus_if.m_last, prev_last);
         end
         if (hold > 0 && n == hold) begin
            check("bp_enb_count", issued, DEPTH);
            check("bp_valid", bus_if.m_valid, 1);
            check("bp_data", bus_if.m_data, ram[a % NWORDS]);
         end
         if (poke) begin
            check("busy_cmd_ready", bus_if.cmd_ready, 0);
            bus_if.cmd_valid = 1'($urandom);
            bus_if.cmd_addr  = AW'($urandom);
            bus_if.cmd_len   = (AW + 1)'($urandom_range(1, NWORDS));
         end
         bus_if.m_ready = (n >= hold) && ($urandom_range(0, 99) < ready_pct);
         if (bus_if.m_valid) begin
            if (first_v < 0) first_v = n;
            if (bus_if.m_ready) begin
               check("beat_data", bus_if.m_data, ram[(a + beats) % NWORDS]);
               check("beat_last", bus_if.m_last, 64'(beats == len - 1));
               $display("cmd a=%0d len=%0d beat %0d data %08h last %0b",
                        a, len, beats, bus_if.m_data, bus_if.m_last);
               beats++;
            end
         end
         prev_stall = bus_if.m_valid && !bus_if.m_ready;
         prev_data  = bus_if.m_data;
         prev_last  = bus_if.m_last;
         if (beats == len) begin
            done = 1;
         end else if (abort_after > 0 && beats == abort_after) begin
            done = 1;
            aborted = 1;
         end else begin
            @(posedge clk); #1;
            n++;
            if (n > 2000) begin
               check("timeout_beats", beats, len);
               done = 1;
               timed_out = 1;
            end
         end
      end
      bus_if.cmd_valid = 1'b0;
      if (aborted) begin
         check("pre_abort_busy", busy, 1);
         @(posedge clk); #3;
         rst = 1'b1;
         #1;
         check("abort_m_valid", bus_if.m_valid, 0);
         check("abort_mem_enb", mem_enb, 0);
         check("abort_busy", busy, 0);
         check("abort_cmd_ready", bus_if.cmd_ready, 1);
         @(posedge clk); #1;
         rst = 1'b0;
      end else if (!timed_out) begin
         @(posedge clk); #1;
         check("end_busy", busy, 0);
         check("end_cmd_ready", bus_if.cmd_ready, 1);
         check("end_m_valid", bus_if.m_valid, 0);
         check("issued_total", issued, len);
         check("outstanding_le_depth", 64'(worst_out <= DEPTH), 1);
         if (chk_lat) begin
            check("first_enb_cycle", first_e, 1);
            check("first_valid_cycle", first_v, LAT + 2);
         end
      end
      bus_if.m_ready = 1'b0;
   endtask

   initial begin
      int act;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_addr  = '0;
      bus_if.cmd_len   = '0;
      bus_if.m_ready   = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < NWORDS; k++) ram[k] = DW'(k * 32'h11);

      // Reset acts without a clock edge
      #1 rst = 1'b1;
      #2;
      check("rst_cmd_ready", bus_if.cmd_ready, 1);
      check("rst_mem_enb", mem_enb, 0);
      check("rst_mem_addrb", mem_addrb, 0);
      check("rst_m_valid", bus_if.m_valid, 0);
      check("rst_m_data", bus_if.m_data, 0);
      check("rst_m_last", bus_if.m_last, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic read, address wrap, and backpressure with credit stall
      run_cmd(5, 3, 100, 0, 0, 1, 0);
      run_cmd(62, 4, 100, 0, 0, 1, 0);
      run_cmd(0, 16, 100, 20, 0, 0, 0);

      // Zero-length command is consumed without any activity
      check("zl_cmd_ready", bus_if.cmd_ready, 1);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_addr  = AW'(7);
      bus_if.cmd_len   = '0;
      @(posedge clk); #1;
      bus_if.cmd_valid = 1'b0;
      check("zl_cmd_ready_next", bus_if.cmd_ready, 1);
      check("zl_busy", busy, 0);
      act = 0;
      repeat (10) begin
         if (mem_enb || bus_if.m_valid) act++;
         @(posedge clk); #1;
      end
      check("zl_activity", act, 0);

      // Full-depth read while commands are offered during busy
      run_cmd(0, 64, 100, 0, 0, 1, 1);

      // Random backpressure
      run_cmd(40, 37, 50, 0, 0, 0, 0);

      // Abort by reset after three beats, then a clean short command
      run_cmd(0, 10, 100, 0, 3, 0, 0);
      run_cmd(9, 2, 100, 0, 0, 1, 0);
      act = 0;
      repeat (8) begin
         if (mem_enb || bus_if.m_valid) act++;
         @(posedge clk); #1;
      end
      check("post_abort_idle", act, 0);

      // Random commands with random throttling
      repeat (4) begin
         run_cmd(int'($urandom_range(0, NWORDS - 1)), int'($urandom_range(1, NWORDS)),
                 int'($urandom_range(30, 100)), 0, 0, 0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
